// File: rtl/cache_mem_arb_pkg.sv
// Shared types and constants for the cache/memory arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : which cache owns (or last owned) the memory port
package cache_mem_arb_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = LINE_W / BEAT_W;
  localparam int OFFSET_W = 5;  // byte offset bits inside one cacheline

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, RESP} arb_state_t;
  typedef enum logic {ICACHE, DCACHE} grant_t;

endpackage

// File: rtl/line_burst_adaptor.sv
// Converts between one cacheline and a burst of BEAT_W-wide memory beats.
//   start     : begin a new burst (clears the beat counter)
//   load      : together with start, loads line_in (writeback data)
//   beat_en   : memory accepted/returned the current beat
//   capture   : burst is a read, so beat_in is stored into the line
//   beat_in   : read beat from memory
//   beat_out  : write beat for the current counter position
//   line_nxt  : line with beat_in inserted at the current position
//   last_beat : counter sits on the final beat
module line_burst_adaptor #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load,
  input  logic [LINE_W-1:0] line_in,
  input  logic              beat_en,
  input  logic              capture,
  input  logic [BEAT_W-1:0] beat_in,
  output logic [BEAT_W-1:0] beat_out,
  output logic [LINE_W-1:0] line_nxt,
  output logic              last_beat
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] line_q;

  always_comb begin
    line_nxt = line_q;
    line_nxt[BEAT_W*cnt +: BEAT_W] = beat_in;
  end

  assign beat_out  = line_q[BEAT_W*cnt +: BEAT_W];
  assign last_beat = (cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      line_q <= '0;
    end else if (start) begin
      cnt <= '0;
      if (load) line_q <= line_in;
    end else if (beat_en) begin
      cnt <= cnt + 1'b1;
      if (capture) line_q <= line_nxt;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one burst memory port between the icache (reads) and the dcache
// (reads and writebacks). One line transfer (BEATS beats) in flight at a time;
// simultaneous requests are granted round-robin.
//   i_read/i_addr -> i_rdata/i_resp          icache side
//   d_read/d_write/d_addr/d_wdata -> d_rdata/d_resp   dcache side
//   mem_read/mem_write/mem_addr/mem_wdata <- mem_rdata/mem_resp   memory side
module cache_mem_arbiter import cache_mem_arb_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFFSET_W) - 1);

  arb_state_t        state;
  grant_t            last_grant;
  logic              d_req, pick_d, start, in_burst, beat_en, last_beat;
  logic [ADDR_W-1:0] addr_sel;
  logic [LINE_W-1:0] line_nxt;

  assign d_req    = d_read | d_write;
  // dcache wins when alone, or on a tie when icache had the last grant
  assign pick_d   = d_req && (!i_read || last_grant == ICACHE);
  assign start    = (state == IDLE) && (i_read || d_req);
  assign addr_sel = pick_d ? d_addr : i_addr;
  assign in_burst = (state == I_RD) || (state == D_RD) || (state == D_WR);
  // mem_resp outside a burst (IDLE/RESP) is ignored
  assign beat_en  = in_burst && mem_resp;

  line_burst_adaptor #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) u_burst (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load      (pick_d && d_write),
    .line_in   (d_wdata),
    .beat_en   (beat_en),
    .capture   (state != D_WR),
    .beat_in   (mem_rdata),
    .beat_out  (mem_wdata),
    .line_nxt  (line_nxt),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ICACHE;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          mem_addr <= addr_sel & ~OFF_MASK;
          if (pick_d) begin
            last_grant <= DCACHE;
            // write wins if the dcache raises both
            if (d_write) begin
              state     <= D_WR;
              mem_write <= 1'b1;
            end else begin
              state    <= D_RD;
              mem_read <= 1'b1;
            end
          end else begin
            last_grant <= ICACHE;
            state      <= I_RD;
            mem_read   <= 1'b1;
          end
        end
        I_RD: if (beat_en && last_beat) begin
          state    <= RESP;
          mem_read <= 1'b0;
          i_resp   <= 1'b1;
          i_rdata  <= line_nxt;
        end
        D_RD: if (beat_en && last_beat) begin
          state    <= RESP;
          mem_read <= 1'b0;
          d_resp   <= 1'b1;
          d_rdata  <= line_nxt;
        end
        D_WR: if (beat_en && last_beat) begin
          state     <= RESP;
          mem_write <= 1'b0;
          d_resp    <= 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: a line-granular memory model (associative
// array of lines) answers bursts with a configurable beat gap; a plain
// round-robin predictor decides who should be served next.
module tb_cache_mem_arbiter;

  localparam int AW = 32, LW = 256, BW = 64, NB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [LW-1:0] i_rdata, d_rdata, d_wdata;
  logic          i_resp, d_resp, mem_read, mem_write;
  logic [BW-1:0] mem_wdata, mem_rdata;
  logic          mem_resp, model_resp, spur_resp;

  assign mem_resp = model_resp | spur_resp;

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .BEAT_W(BW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // ---------------- memory model ----------------
  logic [LW-1:0] mem_line [logic [AW-1:0]];
  logic [AW-1:0] addr_log [$];
  logic [BW-1:0] wr_log [$];
  int            gap = 0;
  int            mbeat = 0, gapc = 0, rd_in_wr = 0;
  bit            active = 0, burst_wr = 0;
  logic [AW-1:0] baddr;
  logic [LW-1:0] acc, tmp;
  logic [BW-1:0] wcap;
  int            ref_last = 0;  // 0 = icache granted last, 1 = dcache

  task automatic ensure_line(input logic [AW-1:0] a);
    if (!mem_line.exists(a))
      mem_line[a] = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    model_resp = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_resp = 1'b0; mbeat = 0; gapc = 0; active = 0;
      end else begin
        if (model_resp) begin  // beat consumed at the last posedge
          if (burst_wr) begin acc[BW*mbeat +: BW] = wcap; wr_log.push_back(wcap); end
          mbeat++;
          if (mbeat == NB && burst_wr) mem_line[baddr] = acc;
        end
        model_resp = 1'b0;
        if (mem_read && mem_write) rd_in_wr++;
        if ((mem_read || mem_write) && mbeat < NB) begin
          if (!active) begin
            active = 1; baddr = mem_addr; burst_wr = mem_write; gapc = 0;
            ensure_line(mem_addr); addr_log.push_back(mem_addr);
          end
          if (burst_wr && mem_read) rd_in_wr++;
          if (gapc > 0) gapc--;
          else begin
            model_resp = 1'b1; gapc = gap;
            tmp = mem_line[baddr]; mem_rdata = tmp[BW*mbeat +: BW];
            wcap = mem_wdata;
          end
        end else if (!mem_read && !mem_write) begin
          mbeat = 0; active = 0;
        end
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic apply_reset();
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; spur_resp = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0; ref_last = 0;
  endtask

  // who: 0 timeout, 1 icache, 2 dcache, 3 both; cyc counted in clocks
  task automatic wait_resp(output int who, output int cyc);
    who = 0; cyc = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk); #1;
      if (i_resp || d_resp) begin
        who = (i_resp && d_resp) ? 3 : (i_resp ? 1 : 2);
        cyc = k;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; spur_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk); #1;
    n_cmp++; if ({i_resp, d_resp, mem_read, mem_write} !== 4'b0) begin n_bad++;
      $display("FAIL reset_ctl: got %b want 0000", {i_resp, d_resp, mem_read, mem_write}); end
    n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_bad++;
      $display("FAIL reset_mem: got addr %h wdata %h want 0", mem_addr, mem_wdata); end
    n_cmp++; if (i_rdata !== '0 || d_rdata !== '0) begin n_bad++;
      $display("FAIL reset_rdata: got %h / %h want 0", i_rdata, d_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_icache_read();
    int who, cyc;
    logic [LW-1:0] line;
    line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    mem_line[32'h1020] = line; gap = 0; addr_log.delete();
    @(negedge clk); #1;
    i_read = 1; i_addr = 32'h0000_1024;
    wait_resp(who, cyc);
    i_read = 0;
    n_cmp++; if (who !== 1) begin n_bad++; $display("FAIL iread_who: got %0d want 1", who); end
    // request cycle 0, mem_read from cycle 1, resp in cycle 5 (6th cycle)
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL iread_latency: got %0d want 5", cyc); end
    n_cmp++; if (i_rdata[63:0] !== {16{4'h1}} || i_rdata !== line) begin n_bad++;
      $display("FAIL iread_line: got %h want %h", i_rdata, line); end
    n_cmp++; if (addr_log.size() != 1 || addr_log[0] !== 32'h1020) begin n_bad++;
      $display("FAIL iread_addr: got %h want 00001020", addr_log.size() ? addr_log[0] : 'x); end
    @(negedge clk); #1;
    n_cmp++; if (i_resp !== 1'b0) begin n_bad++; $display("FAIL iread_pulse: got %b want 0", i_resp); end
  endtask

  task automatic test_writeback();
    int who, cyc;
    logic [BW-1:0] b [4];
    for (int k = 0; k < 4; k++) b[k] = {$urandom, $urandom};
    gap = 1; addr_log.delete(); wr_log.delete(); rd_in_wr = 0;
    @(negedge clk); #1;
    d_write = 1; d_addr = 32'h80; d_wdata = {b[3], b[2], b[1], b[0]};
    wait_resp(who, cyc);
    d_write = 0;
    n_cmp++; if (who !== 2) begin n_bad++; $display("FAIL wb_who: got %0d want 2", who); end
    n_cmp++; if (wr_log.size() != 4) begin n_bad++; $display("FAIL wb_beats: got %0d want 4", wr_log.size()); end
    else for (int k = 0; k < 4; k++) begin
      n_cmp++; if (wr_log[k] !== b[k]) begin n_bad++;
        $display("FAIL wb_beat%0d: got %h want %h", k, wr_log[k], b[k]); end
    end
    n_cmp++; if (mem_line[32'h80] !== {b[3], b[2], b[1], b[0]}) begin n_bad++;
      $display("FAIL wb_mem: got %h", mem_line[32'h80]); end
    n_cmp++; if (addr_log.size() != 1 || addr_log[0] !== 32'h80) begin n_bad++;
      $display("FAIL wb_addr: got %h want 00000080", addr_log.size() ? addr_log[0] : 'x); end
    n_cmp++; if (rd_in_wr != 0) begin n_bad++; $display("FAIL wb_noread: got %0d want 0", rd_in_wr); end
    @(negedge clk); #1;
    n_cmp++; if (d_resp !== 1'b0) begin n_bad++; $display("FAIL wb_pulse: got %b want 0", d_resp); end
  endtask

  task automatic test_tie();
    int who, cyc;
    apply_reset();
    gap = 0;
    @(negedge clk); #1;
    i_read = 1; i_addr = 32'h3000; d_read = 1; d_addr = 32'h5000;
    wait_resp(who, cyc);  // first tie after reset
    n_cmp++; if (who !== 2) begin n_bad++; $display("FAIL tie1: got %0d want 2", who); end
    // dcache keeps its request up: a fresh tie, dcache had the last grant
    wait_resp(who, cyc);
    i_read = 0;
    n_cmp++; if (who !== 1) begin n_bad++; $display("FAIL tie2: got %0d want 1", who); end
    wait_resp(who, cyc);
    d_read = 0;
    n_cmp++; if (who !== 2) begin n_bad++; $display("FAIL tie3: got %0d want 2", who); end
    ref_last = 1;
  endtask

  task automatic test_stall();
    int who, cyc;
    logic [LW-1:0] line;
    ensure_line(32'h1100); line = mem_line[32'h1100]; gap = 3;
    @(negedge clk); #1;
    i_read = 1; i_addr = 32'h111F;
    wait_resp(who, cyc);
    i_read = 0;
    n_cmp++; if (who !== 1) begin n_bad++; $display("FAIL stall_who: got %0d want 1", who); end
    n_cmp++; if (cyc !== 1 + NB + 3 * (NB - 1)) begin n_bad++;
      $display("FAIL stall_latency: got %0d want %0d", cyc, 1 + NB + 3 * (NB - 1)); end
    n_cmp++; if (i_rdata !== line) begin n_bad++; $display("FAIL stall_line: got %h want %h", i_rdata, line); end
    ref_last = 0;
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      int mode, who, cyc, pred, first;
      bit pi, pd, dw;
      logic [AW-1:0] ia, da;
      logic [LW-1:0] exp_i, exp_d, wd;
      mode = $urandom_range(0, 2); gap = $urandom_range(0, 2);
      pi = (mode != 1); pd = (mode != 0); dw = $urandom_range(0, 1);
      ia = 32'h1000 + ($urandom_range(0, 63) << 5) + $urandom_range(0, 31);
      da = 32'h4000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
      wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ensure_line(ia & ~32'h1F); ensure_line(da & ~32'h1F);
      exp_i = mem_line[ia & ~32'h1F]; exp_d = mem_line[da & ~32'h1F];
      @(negedge clk); #1;
      i_read = pi; i_addr = ia;
      d_read = pd && !dw; d_write = pd && dw; d_addr = da; d_wdata = wd;
      first = 1;
      while (pi || pd) begin
        pred = (pi && pd) ? (ref_last == 0 ? 2 : 1) : (pi ? 1 : 2);
        wait_resp(who, cyc);
        n_cmp++; if (who !== pred) begin n_bad++;
          $display("FAIL rnd%0d_who: got %0d want %0d", t, who, pred); end
        if (first) begin
          n_cmp++; if (cyc !== 1 + NB + gap * (NB - 1)) begin n_bad++;
            $display("FAIL rnd%0d_latency: got %0d want %0d", t, cyc, 1 + NB + gap * (NB - 1)); end
        end
        first = 0;
        if (who == 0) begin i_read = 0; d_read = 0; d_write = 0; break; end
        if (pred == 1) begin
          i_read = 0; pi = 0; ref_last = 0;
          n_cmp++; if (i_rdata !== exp_i) begin n_bad++;
            $display("FAIL rnd%0d_iline: got %h want %h", t, i_rdata, exp_i); end
        end else begin
          d_read = 0; d_write = 0; pd = 0; ref_last = 1;
          if (dw) begin
            n_cmp++; if (mem_line[da & ~32'h1F] !== wd) begin n_bad++;
              $display("FAIL rnd%0d_wb: got %h want %h", t, mem_line[da & ~32'h1F], wd); end
          end else begin
            n_cmp++; if (d_rdata !== exp_d) begin n_bad++;
              $display("FAIL rnd%0d_dline: got %h want %h", t, d_rdata, exp_d); end
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int who, cyc, k;
    logic [LW-1:0] line;
    ensure_line(32'h1A00); line = mem_line[32'h1A00]; gap = 1;
    @(negedge clk); #1;
    i_read = 1; i_addr = 32'h1A08;
    for (k = 0; k < 50 && mbeat < 2; k++) begin @(negedge clk); #1; end
    n_cmp++; if (mbeat != 2) begin n_bad++; $display("FAIL rstmid_beats: got %0d want 2", mbeat); end
    rst = 1'b1; #1;
    n_cmp++; if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0) begin n_bad++;
      $display("FAIL rstmid_ctl: got %b want 0000", {mem_read, mem_write, i_resp, d_resp}); end
    n_cmp++; if (i_rdata !== '0 || d_rdata !== '0) begin n_bad++;
      $display("FAIL rstmid_rdata: got %h / %h want 0", i_rdata, d_rdata); end
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0; ref_last = 0; addr_log.delete();
    wait_resp(who, cyc);  // i_read still high: reissued after release
    i_read = 0;
    n_cmp++; if (who !== 1) begin n_bad++; $display("FAIL rstmid_who: got %0d want 1", who); end
    n_cmp++; if (i_rdata !== line) begin n_bad++;
      $display("FAIL rstmid_line: got %h want %h", i_rdata, line); end
  endtask

  task automatic test_spurious();
    int who, cyc, seen;
    logic [LW-1:0] line, wd;
    gap = 0; seen = 0;
    @(negedge clk); #1;
    spur_resp = 1;
    @(negedge clk); #1;
    spur_resp = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      if (i_resp || d_resp || mem_read || mem_write) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL spur_idle: got %0d active cycles want 0", seen); end
    // a following read must still start at beat 0
    ensure_line(32'h1E00); line = mem_line[32'h1E00];
    i_read = 1; i_addr = 32'h1E00;
    wait_resp(who, cyc);
    i_read = 0;
    n_cmp++; if (who !== 1 || i_rdata !== line) begin n_bad++;
      $display("FAIL spur_after: got who %0d line %h want 1 %h", who, i_rdata, line); end
    wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rd_in_wr = 0; wr_log.delete();
    @(negedge clk); #1;
    d_read = 1; d_write = 1; d_addr = 32'h2A4; d_wdata = wd;
    wait_resp(who, cyc);
    d_read = 0; d_write = 0;
    n_cmp++; if (who !== 2) begin n_bad++; $display("FAIL rdwr_who: got %0d want 2", who); end
    n_cmp++; if (mem_line[32'h2A0] !== wd || wr_log.size() != 4 || rd_in_wr != 0) begin n_bad++;
      $display("FAIL rdwr_write: got %h beats %0d rd %0d want %h 4 0",
               mem_line[32'h2A0], wr_log.size(), rd_in_wr, wd); end
  endtask

  initial begin
    spur_resp = 0;
    test_reset();
    test_icache_read();
    test_writeback();
    test_tie();
    test_stall();
    test_random(24);
    test_reset_mid_burst();
    test_spurious();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
